// File: rtl/sdlx_decode_control.sv
// SDLX decode/control FSM: accepts one instruction per valid/ready handshake,
// decodes the R/I/J formats and sequences DECODE -> EXEC -> MEM -> WB,
// driving register-file addresses, ALU controls, memory strobes and PC redirect.
module sdlx_decode_control #(
    parameter int          ALU_OP_W = 3,
    parameter logic [5:0]  HALT_OPC = 6'h3F
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         instr,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [31:0]         rs1_data,
    output logic [4:0]          readaddr1,
    output logic [4:0]          readaddr2,
    output logic [4:0]          writeaddr,
    output logic                reg_write,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                alu_src_imm,
    output logic [31:0]         imm,
    output logic                mem_read,
    output logic                mem_write,
    output logic                pc_load,
    output logic                halted,
    output logic                illegal
);

    localparam logic [ALU_OP_W-1:0] OP_ADD = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] OP_SUB = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] OP_AND = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] OP_OR  = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] OP_XOR = ALU_OP_W'(4);
    localparam logic [ALU_OP_W-1:0] OP_SLT = ALU_OP_W'(5);

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED
    } state_t;

    typedef enum logic [2:0] {
        K_BAD, K_ALU, K_LW, K_SW, K_BEQZ, K_BNEZ, K_J, K_HALT
    } kind_t;

    state_t              state, state_nxt;
    logic [31:0]         ir;          // latched instruction
    logic                illegal_q;
    kind_t               kind;
    logic [ALU_OP_W-1:0] op_dec;
    logic                is_imm;
    logic [4:0]          rd;
    logic [31:0]         imm_ext;
    logic [5:0]          opc;
    logic [5:0]          func;

    assign opc  = ir[31:26];
    assign func = ir[5:0];

    // Classify the latched instruction and derive ALU/immediate controls.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        kind    = K_BAD;
        op_dec  = OP_ADD;
        is_imm  = 1'b0;
        rd      = ir[20:16];
        imm_ext = {{16{ir[15]}}, ir[15:0]};
        if (opc == HALT_OPC) begin
            kind = K_HALT;
        end else begin
            unique case (opc)
                6'h00: begin
                    rd   = ir[15:11];
                    kind = K_ALU;
                    unique case (func)
                        6'h20:   op_dec = OP_ADD;
                        6'h22:   op_dec = OP_SUB;
                        6'h24:   op_dec = OP_AND;
                        6'h25:   op_dec = OP_OR;
                        6'h26:   op_dec = OP_XOR;
                        6'h2A:   op_dec = OP_SLT;
                        default: kind   = K_BAD;
                    endcase
                end
                6'h08: begin kind = K_ALU; is_imm = 1'b1; end
                6'h0C: begin
                    kind = K_ALU; is_imm = 1'b1; op_dec = OP_AND;
                    imm_ext = {16'h0000, ir[15:0]};
                end
                6'h0D: begin
                    kind = K_ALU; is_imm = 1'b1; op_dec = OP_OR;
                    imm_ext = {16'h0000, ir[15:0]};
                end
                6'h23:   begin kind = K_LW; is_imm = 1'b1; end
                6'h2B:   begin kind = K_SW; is_imm = 1'b1; end
                6'h04:   kind = K_BEQZ;
                6'h05:   kind = K_BNEZ;
                6'h02: begin
                    kind    = K_J;
                    imm_ext = {{6{ir[25]}}, ir[25:0]};
                end
                default: kind = K_BAD;
            endcase
        end
    end

    // State, latched instruction and sticky illegal flag.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state     <= S_IDLE;
            ir        <= '0;
            illegal_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && instr_valid) ir <= instr;
            if (state == S_DECODE && kind == K_BAD) illegal_q <= 1'b1;
        end
    end

    // Next-state and strobe generation; reset forces the idle output pattern
    // combinationally so an in-flight write or store never reaches the edge.
    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        pc_load     = 1'b0;
        if (reset) begin
            state_nxt   = S_IDLE;
            instr_ready = 1'b1;
        end else begin
            unique case (state)
                S_IDLE: begin
                    instr_ready = 1'b1;
                    if (instr_valid) state_nxt = S_DECODE;
                end
                S_DECODE: begin
                    if (kind == K_BAD)       state_nxt = S_IDLE;
                    else if (kind == K_HALT) state_nxt = S_HALTED;
                    else                     state_nxt = S_EXEC;
                end
                S_EXEC: begin
                    state_nxt = S_IDLE;
                    unique case (kind)
                        K_BEQZ:      pc_load = (rs1_data == 32'd0);
                        K_BNEZ:      pc_load = (rs1_data != 32'd0);
                        K_J:         pc_load = 1'b1;
                        K_LW, K_SW:  state_nxt = S_MEM;
                        K_ALU:       state_nxt = S_WB;
                        default:     state_nxt = S_IDLE;
                    endcase
                end
                S_MEM: begin
                    if (kind == K_LW) begin
                        mem_read  = 1'b1;
                        state_nxt = S_WB;
                    end else begin
                        mem_write = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
                S_WB: begin
                    reg_write = (rd != 5'd0);
                    state_nxt = S_IDLE;
                end
                S_HALTED: state_nxt = S_HALTED;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    assign readaddr1   = ir[25:21];
    assign readaddr2   = ir[20:16];
    assign writeaddr   = rd;
    assign alu_op      = op_dec;
    assign alu_src_imm = is_imm;
    assign imm         = imm_ext;
    assign halted      = (state == S_HALTED) && !reset;
    assign illegal     = illegal_q && !reset;

endmodule

// File: tb/tb_sdlx_decode_control.sv
// Self-checking bench for sdlx_decode_control: a per-instruction phase-timeline
// model feeds an expectation queue checked every cycle, plus literal latency,
// strobe-count and immediate expectations per directed vector.
module tb_sdlx_decode_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] rs1_data;
    logic [4:0]  readaddr1, readaddr2, writeaddr;
    logic        reg_write;
    logic [2:0]  alu_op;
    logic        alu_src_imm;
    logic [31:0] imm;
    logic        mem_read, mem_write, pc_load, halted, illegal;

    sdlx_decode_control dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .rs1_data(rs1_data), .readaddr1(readaddr1),
        .readaddr2(readaddr2), .writeaddr(writeaddr), .reg_write(reg_write),
        .alu_op(alu_op), .alu_src_imm(alu_src_imm), .imm(imm),
        .mem_read(mem_read), .mem_write(mem_write), .pc_load(pc_load),
        .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef enum logic [2:0] {P_IDLE, P_DEC, P_EXE, P_MEM, P_WB, P_HALT} ph_t;

    typedef struct packed {
        ph_t        ph;
        logic       rdy, rw, mr, mw, pc, hlt, ill;
        logic       ck_ra;
        logic [4:0] ra1, ra2;
        logic       ck_alu;
        logic [2:0] op;
        logic       src;
        logic       ck_imm;
        logic [31:0] iv;
        logic       ck_wa;
        logic [4:0] wa;
    } exp_t;

    exp_t        q[$];
    bit          sticky_ill = 1'b0;
    int          n_checks = 0;
    int          n_err = 0;
    int          rw_n, mr_n, mw_n, pc_n;
    logic [31:0] last_imm;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t blank(input ph_t p);
        exp_t e;
        e     = '0;
        e.ph  = p;
        e.ill = sticky_ill;
        return e;
    endfunction

    // Spec-level model: classify the instruction, then emit one expectation
    // per cycle from the handshake cycle until the block is idle again.
    task automatic model(input logic [31:0] ins, input logic [31:0] r1);
        int          kind;   // 0 R-ALU, 1 I-ALU, 2 LW, 3 SW, 4 branch, 5 J, 6 HALT, 7 bad
        logic [2:0]  op;
        logic [31:0] iv;
        logic [4:0]  rd;
        logic        taken;
        logic [5:0]  opc;
        logic [5:0]  fn;
        exp_t        e;
        opc = ins[31:26];
        fn = ins[5:0];
        op = 3'd0;
        rd = ins[20:16];
        iv = {{16{ins[15]}}, ins[15:0]};
        taken = 1'b0;
        kind = 7;
        case (opc)
            6'h00: begin
                rd = ins[15:11];
                kind = 0;
                case (fn)
                    6'h20: op = 3'd0;
                    6'h22: op = 3'd1;
                    6'h24: op = 3'd2;
                    6'h25: op = 3'd3;
                    6'h26: op = 3'd4;
                    6'h2A: op = 3'd5;
                    default: kind = 7;
                endcase
            end
            6'h08: kind = 1;
            6'h0C: begin kind = 1; op = 3'd2; iv = {16'h0, ins[15:0]}; end
            6'h0D: begin kind = 1; op = 3'd3; iv = {16'h0, ins[15:0]}; end
            6'h23: kind = 2;
            6'h2B: kind = 3;
            6'h04: begin kind = 4; taken = (r1 == 0); end
            6'h05: begin kind = 4; taken = (r1 != 0); end
            6'h02: begin kind = 5; iv = {{6{ins[25]}}, ins[25:0]}; end
            6'h3F: kind = 6;
            default: kind = 7;
        endcase

        e = blank(P_IDLE); e.rdy = 1'b1; q.push_back(e);
        e = blank(P_DEC); e.ck_ra = 1'b1; e.ra1 = ins[25:21]; e.ra2 = ins[20:16]; q.push_back(e);
        if (kind == 7) begin
            sticky_ill = 1'b1;
        end else if (kind == 6) begin
            repeat (5) begin e = blank(P_HALT); e.hlt = 1'b1; q.push_back(e); end
        end else begin
            e = blank(P_EXE);
            e.ck_alu = (kind <= 3);
            e.op = op;
            e.src = (kind != 0);
            e.ck_imm = (kind >= 1 && kind <= 5);
            e.iv = iv;
            e.pc = (kind == 4 && taken) || kind == 5;
            q.push_back(e);
            if (kind == 2 || kind == 3) begin
                e = blank(P_MEM); e.mr = (kind == 2); e.mw = (kind == 3); q.push_back(e);
            end
            if (kind <= 2) begin
                e = blank(P_WB); e.rw = (rd != 0); e.ck_wa = 1'b1; e.wa = rd; q.push_back(e);
            end
        end
    endtask

    // Per-cycle compare against the model and strobe counting.
    always @(negedge clk) begin
        exp_t e;
        if (reg_write) rw_n++;
        if (mem_read)  mr_n++;
        if (mem_write) mw_n++;
        if (pc_load)   pc_n++;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("cyc_instr_ready", {31'd0, instr_ready}, {31'd0, e.rdy});
            check("cyc_reg_write",   {31'd0, reg_write},   {31'd0, e.rw});
            check("cyc_mem_read",    {31'd0, mem_read},    {31'd0, e.mr});
            check("cyc_mem_write",   {31'd0, mem_write},   {31'd0, e.mw});
            check("cyc_pc_load",     {31'd0, pc_load},     {31'd0, e.pc});
            check("cyc_halted",      {31'd0, halted},      {31'd0, e.hlt});
            check("cyc_illegal",     {31'd0, illegal},     {31'd0, e.ill});
            if (e.ck_ra) begin
                check("dec_readaddr1", {27'd0, readaddr1}, {27'd0, e.ra1});
                check("dec_readaddr2", {27'd0, readaddr2}, {27'd0, e.ra2});
            end
            if (e.ck_alu) begin
                check("exe_alu_op",      {29'd0, alu_op},      {29'd0, e.op});
                check("exe_alu_src_imm", {31'd0, alu_src_imm}, {31'd0, e.src});
            end
            if (e.ck_imm) check("exe_imm", imm, e.iv);
            if (e.ck_wa)  check("wb_writeaddr", {27'd0, writeaddr}, {27'd0, e.wa});
            if (e.ph == P_EXE) last_imm = imm;
        end
    end

    // Issue one instruction and check hand-computed latency and strobe counts.
    task automatic run(input string nm, input logic [31:0] ins, input logic [31:0] r1,
                       input int lat_e, input int rw_e, input int mr_e, input int mw_e,
                       input int pc_e, input bit ck_i, input logic [31:0] imm_e);
        int lat;
        instr = ins;
        rs1_data = r1;
        instr_valid = 1'b1;
        rw_n = 0; mr_n = 0; mw_n = 0; pc_n = 0;
        model(ins, r1);
        lat = 0;
        do begin
            @(posedge clk); #1;
            instr_valid = 1'b0;
            lat++;
        end while (!instr_ready && lat < 20);
        check({nm, "_latency"},   lat,  lat_e);
        check({nm, "_reg_write"}, rw_n, rw_e);
        check({nm, "_mem_read"},  mr_n, mr_e);
        check({nm, "_mem_write"}, mw_n, mw_e);
        check({nm, "_pc_load"},   pc_n, pc_e);
        check({nm, "_q_drain"},   q.size(), 0);
        if (ck_i) check({nm, "_imm"}, last_imm, imm_e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        instr = '0;
        instr_valid = 1'b0;
        rs1_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_instr_ready", {31'd0, instr_ready}, 32'd1);
        reset = 1'b0;
        #1;
        check("rst_instr_ready_rel", {31'd0, instr_ready}, 32'd1);
        check("rst_reg_write", {31'd0, reg_write}, 32'd0);
        check("rst_pc_load",   {31'd0, pc_load},   32'd0);
        check("rst_halted",    {31'd0, halted},    32'd0);
        check("rst_illegal",   {31'd0, illegal},   32'd0);
        check("rst_readaddr1", {27'd0, readaddr1}, 32'd0);

        //   name     instr         rs1  lat rw mr mw pc  imm-check
        run("add",    32'h00221820, 0,   4,  1, 0, 0, 0,  1'b0, 32'h0);
        run("addi",   32'h2005FFFC, 0,   4,  1, 0, 0, 0,  1'b1, 32'hFFFFFFFC);
        run("ori",    32'h34058000, 0,   4,  1, 0, 0, 0,  1'b1, 32'h00008000);
        run("lw",     32'h8C240008, 0,   5,  1, 1, 0, 0,  1'b1, 32'h00000008);
        run("sw",     32'hAC240008, 0,   4,  0, 0, 1, 0,  1'b1, 32'h00000008);
        run("beqz_t", 32'h10200010, 0,   3,  0, 0, 0, 1,  1'b1, 32'h00000010);
        run("beqz_n", 32'h10200010, 7,   3,  0, 0, 0, 0,  1'b0, 32'h0);
        run("bnez_t", 32'h1420FFF0, 7,   3,  0, 0, 0, 1,  1'b1, 32'hFFFFFFF0);
        run("bnez_n", 32'h1420FFF0, 0,   3,  0, 0, 0, 0,  1'b0, 32'h0);
        run("j",      32'h0BFFFFF8, 0,   3,  0, 0, 0, 1,  1'b1, 32'hFFFFFFF8);
        run("add_r0", 32'h00220020, 0,   4,  0, 0, 0, 0,  1'b0, 32'h0);
        run("sub",    32'h00223022, 0,   4,  1, 0, 0, 0,  1'b0, 32'h0);
        run("and",    32'h00223824, 0,   4,  1, 0, 0, 0,  1'b0, 32'h0);
        run("or",     32'h00225025, 0,   4,  1, 0, 0, 0,  1'b0, 32'h0);
        run("xor",    32'h00224826, 0,   4,  1, 0, 0, 0,  1'b0, 32'h0);
        run("slt",    32'h0022402A, 0,   4,  1, 0, 0, 0,  1'b0, 32'h0);
        run("andi",   32'h3025F0F0, 0,   4,  1, 0, 0, 0,  1'b1, 32'h0000F0F0);
        run("bad_op", 32'hF8000000, 0,   2,  0, 0, 0, 0,  1'b0, 32'h0);
        run("bad_fn", 32'h0022183F, 0,   2,  0, 0, 0, 0,  1'b0, 32'h0);
        check("illegal_sticky", {31'd0, illegal}, 32'd1);

        // Reset during the WB cycle of ADD r3: the write must be dropped.
        instr = 32'h00221820;
        instr_valid = 1'b1;
        @(posedge clk); #1; instr_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("wbrst_pre_reg_write", {31'd0, reg_write}, 32'd1);
        check("wbrst_pre_writeaddr", {27'd0, writeaddr}, 32'd3);
        reset = 1'b1;
        #1;
        check("wbrst_during_reg_write", {31'd0, reg_write}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        sticky_ill = 1'b0;
        #1;
        check("wbrst_reg_write",   {31'd0, reg_write},   32'd0);
        check("wbrst_instr_ready", {31'd0, instr_ready}, 32'd1);
        check("wbrst_illegal",     {31'd0, illegal},     32'd0);
        check("wbrst_halted",      {31'd0, halted},      32'd0);

        // HALT parks the FSM; instr_valid held high must be ignored.
        instr = 32'hFC000000;
        instr_valid = 1'b1;
        model(instr, 0);
        repeat (7) begin @(posedge clk); #1; end
        check("halt_halted",      {31'd0, halted},      32'd1);
        check("halt_instr_ready", {31'd0, instr_ready}, 32'd0);
        check("halt_q_drain",     q.size(),             0);
        instr_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("halt_rst_halted",      {31'd0, halted},      32'd0);
        check("halt_rst_instr_ready", {31'd0, instr_ready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
